// File: rtl/eth_frame_log_arbiter.sv
// Round-robin arbiter that merges per-source {control, frame-data} log records into one atomic output stream.
// Optional counters (srst, record_count, stall_cycles) are built when ETH_FRAME_LOG_ARBITER_STATS_EN is defined.
module eth_frame_log_arbiter #(
   parameter int C_NUM_SOURCES      = 2,
   parameter int C_NUM_SCRIPTS_CEIL = 8,
   parameter int C_AXIS_LOG_WIDTH   = 64
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              enable,
   input  logic [C_NUM_SOURCES*(C_NUM_SCRIPTS_CEIL+80)-1:0]  s_axis_ctl_tdata,
   input  logic [C_NUM_SOURCES-1:0]                          s_axis_ctl_tvalid,
   output logic [C_NUM_SOURCES-1:0]                          s_axis_ctl_tready,
   input  logic [C_NUM_SOURCES*C_AXIS_LOG_WIDTH-1:0]         s_axis_frame_tdata,
   input  logic [C_NUM_SOURCES-1:0]                          s_axis_frame_tvalid,
   output logic [C_NUM_SOURCES-1:0]                          s_axis_frame_tready,
   output logic [C_NUM_SCRIPTS_CEIL+83:0]                    m_axis_ctl_tdata,
   output logic                                              m_axis_ctl_tvalid,
   input  logic                                              m_axis_ctl_tready,
   output logic [C_AXIS_LOG_WIDTH-1:0]                       m_axis_frame_tdata,
   output logic                                              m_axis_frame_tlast,
   output logic                                              m_axis_frame_tvalid,
   input  logic                                              m_axis_frame_tready
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
   ,
   input  logic                                              srst,
   output logic [63:0]                                       record_count,
   output logic [63:0]                                       stall_cycles
`endif
);

   localparam int CW  = C_NUM_SCRIPTS_CEIL + 80;
   localparam int BPW = C_AXIS_LOG_WIDTH / 8;
   localparam int GW  = $clog2(C_NUM_SOURCES);

   typedef enum logic [1:0] {ST_IDLE, ST_CTL, ST_FRAME} state_t;

   state_t        state;
   logic [GW-1:0] grant;
   logic [GW-1:0] last_grant;
   logic [16:0]   remaining;

   logic [GW-1:0] pick;
   logic [GW-1:0] idx;
   logic          pick_valid;
   logic [CW-1:0] pick_word;
   logic [16:0]   pick_words;
   logic          frame_hs;

   // Search starts just after the previous winner so every source gets a turn.
   always_comb begin
      pick       = '0;
      idx        = '0;
      pick_valid = 1'b0;
      for (int k = 1; k <= C_NUM_SOURCES; k++) begin
         idx = GW'((int'(last_grant) + k) % C_NUM_SOURCES);
         if (!pick_valid && s_axis_ctl_tvalid[idx]) begin
            pick_valid = 1'b1;
            pick       = idx;
         end
      end
   end

   // 17-bit word count so a SIZE of 0xFFFF rounds up without wrapping.
   assign pick_word  = s_axis_ctl_tdata[int'(pick)*CW +: CW];
   assign pick_words = (17'(pick_word[79:64]) + 17'(BPW - 1)) / 17'(BPW);

   always_comb begin
      s_axis_ctl_tready   = '0;
      s_axis_frame_tready = '0;
      m_axis_frame_tvalid = 1'b0;
      m_axis_frame_tdata  = '0;
      if (state == ST_CTL)
         s_axis_ctl_tready[grant] = m_axis_ctl_tready;
      if (state == ST_FRAME) begin
         m_axis_frame_tvalid        = s_axis_frame_tvalid[grant];
         m_axis_frame_tdata         = s_axis_frame_tdata[int'(grant)*C_AXIS_LOG_WIDTH +: C_AXIS_LOG_WIDTH];
         s_axis_frame_tready[grant] = m_axis_frame_tready;
      end
   end

   assign m_axis_frame_tlast = (state == ST_FRAME) && (remaining == 17'd1);
   assign frame_hs           = m_axis_frame_tvalid && m_axis_frame_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         grant             <= '0;
         last_grant        <= GW'(C_NUM_SOURCES - 1);
         remaining         <= '0;
         m_axis_ctl_tvalid <= 1'b0;
         m_axis_ctl_tdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable && pick_valid) begin
                  grant             <= pick;
                  last_grant        <= pick;
                  remaining         <= pick_words;
                  m_axis_ctl_tdata  <= {4'(pick), pick_word};
                  m_axis_ctl_tvalid <= 1'b1;
                  state             <= ST_CTL;
               end
            end
            ST_CTL: begin
               if (m_axis_ctl_tready) begin
                  m_axis_ctl_tvalid <= 1'b0;
                  state             <= (remaining == 17'd0) ? ST_IDLE : ST_FRAME;
               end
            end
            ST_FRAME: begin
               if (frame_hs) begin
                  remaining <= remaining - 17'd1;
                  if (remaining == 17'd1)
                     state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
   logic record_done;
   logic stall_now;

   assign record_done = ((state == ST_CTL) && m_axis_ctl_tready && (remaining == 17'd0)) ||
                        (frame_hs && (remaining == 17'd1));
   assign stall_now   = (state == ST_FRAME) && !s_axis_frame_tvalid[grant];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         record_count <= '0;
         stall_cycles <= '0;
      end else if (srst) begin
         record_count <= '0;
         stall_cycles <= '0;
      end else begin
         if (record_done)
            record_count <= record_count + 64'd1;
         if (stall_now)
            stall_cycles <= stall_cycles + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_eth_frame_log_arbiter.sv
// Directed bench for eth_frame_log_arbiter: source models, in-order record scoreboard and routing checks.
module tb_eth_frame_log_arbiter;

   localparam int NS = 2;
   localparam int NSC = 8;
   localparam int DW = 64;
   localparam int CW = NSC + 80;
   localparam int OW = CW + 4;

   logic            clk, rst, enable;
   logic [NS*CW-1:0] s_axis_ctl_tdata;
   logic [NS-1:0]   s_axis_ctl_tvalid, s_axis_ctl_tready;
   logic [NS*DW-1:0] s_axis_frame_tdata;
   logic [NS-1:0]   s_axis_frame_tvalid, s_axis_frame_tready;
   logic [OW-1:0]   m_axis_ctl_tdata;
   logic            m_axis_ctl_tvalid, m_axis_ctl_tready;
   logic [DW-1:0]   m_axis_frame_tdata;
   logic            m_axis_frame_tlast, m_axis_frame_tvalid, m_axis_frame_tready;
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
   logic            srst;
   logic [63:0]     record_count, stall_cycles;
`endif

   int checks = 0;
   int failures = 0;

   logic [CW-1:0] src_ctl_q [NS][$];
   logic [DW-1:0] src_frame_q [NS][$];
   int            popped [NS];
   int            gap_at [NS];
   int            gap_cnt [NS];
   logic [NS-1:0] ctl_hs, frame_hs;

   logic [OW-1:0] exp_ctl [$];
   int            exp_words [$];
   logic [DW:0]   exp_frame [$];
   logic          in_frame;
   int            cur_src;
   int            frames_seen;
   logic          rand_rdy;

   eth_frame_log_arbiter #(
      .C_NUM_SOURCES(NS), .C_NUM_SCRIPTS_CEIL(NSC), .C_AXIS_LOG_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .s_axis_ctl_tdata(s_axis_ctl_tdata), .s_axis_ctl_tvalid(s_axis_ctl_tvalid),
      .s_axis_ctl_tready(s_axis_ctl_tready),
      .s_axis_frame_tdata(s_axis_frame_tdata), .s_axis_frame_tvalid(s_axis_frame_tvalid),
      .s_axis_frame_tready(s_axis_frame_tready),
      .m_axis_ctl_tdata(m_axis_ctl_tdata), .m_axis_ctl_tvalid(m_axis_ctl_tvalid),
      .m_axis_ctl_tready(m_axis_ctl_tready),
      .m_axis_frame_tdata(m_axis_frame_tdata), .m_axis_frame_tlast(m_axis_frame_tlast),
      .m_axis_frame_tvalid(m_axis_frame_tvalid), .m_axis_frame_tready(m_axis_frame_tready)
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
      , .srst(srst), .record_count(record_count), .stall_cycles(stall_cycles)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Records must be loaded in the order the round-robin is expected to grant them.
   task automatic applyStimulus(input int src, input logic [15:0] size, input logic [7:0] tag);
      logic [CW-1:0] w;
      logic [DW-1:0] d;
      int words;
      w = {tag, size, 32'hC0DE_0000, 16'h0000, tag, 8'(src)};
      src_ctl_q[src].push_back(w);
      exp_ctl.push_back({4'(src), w});
      words = (int'(size) + 7) / 8;
      exp_words.push_back(words);
      for (int j = 0; j < words; j++) begin
         d = {8'(src), tag, 16'(j), 32'hF00D_0000 + 32'(j)};
         src_frame_q[src].push_back(d);
         exp_frame.push_back({(j == words - 1), d});
      end
   endtask

   task automatic waitDone(input int budget, input string tag);
      int n;
      n = 0;
      while ((exp_ctl.size() != 0 || exp_frame.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      checkOutput(tag, exp_ctl.size() + exp_frame.size(), 0);
      exp_ctl.delete();
      exp_words.delete();
      exp_frame.delete();
      repeat (3) @(posedge clk);
      #2;
      checkOutput({tag, "_ctl_valid_after"}, m_axis_ctl_tvalid, 0);
   endtask

   // Source and sink drivers: update just after each rising edge from handshakes seen at the prior falling edge.
   initial begin
      s_axis_ctl_tdata    = '0;
      s_axis_ctl_tvalid   = '0;
      s_axis_frame_tdata  = '0;
      s_axis_frame_tvalid = '0;
      m_axis_ctl_tready   = 1'b1;
      m_axis_frame_tready = 1'b1;
      for (int i = 0; i < NS; i++) begin
         popped[i]  = 0;
         gap_cnt[i] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NS; i++) begin
            if (ctl_hs[i] && src_ctl_q[i].size() > 0)
               void'(src_ctl_q[i].pop_front());
            if (frame_hs[i] && src_frame_q[i].size() > 0) begin
               void'(src_frame_q[i].pop_front());
               popped[i]++;
               if (popped[i] == gap_at[i])
                  gap_cnt[i] = 5;
            end
            s_axis_ctl_tvalid[i]        = src_ctl_q[i].size() > 0;
            s_axis_ctl_tdata[i*CW +: CW] = (src_ctl_q[i].size() > 0) ? src_ctl_q[i][0] : '0;
            if (gap_cnt[i] > 0) begin
               s_axis_frame_tvalid[i] = 1'b0;
               gap_cnt[i]--;
            end else begin
               s_axis_frame_tvalid[i] = src_frame_q[i].size() > 0;
            end
            s_axis_frame_tdata[i*DW +: DW] = (src_frame_q[i].size() > 0) ? src_frame_q[i][0] : '0;
         end
         m_axis_ctl_tready   = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
         m_axis_frame_tready = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   // Output monitor: in-order scoreboard, hold-while-stalled and ready routing checks.
   initial begin
      logic [NS-1:0] exp_rdy;
      logic [OW-1:0] head;
      in_frame    = 1'b0;
      cur_src     = 0;
      frames_seen = 0;
      ctl_hs      = '0;
      frame_hs    = '0;
      forever begin
         @(negedge clk);
         ctl_hs   = s_axis_ctl_tvalid & s_axis_ctl_tready;
         frame_hs = s_axis_frame_tvalid & s_axis_frame_tready;
         if (rst) begin
            in_frame = 1'b0;
            ctl_hs   = '0;
            frame_hs = '0;
         end else begin
            exp_rdy = in_frame ? (NS'(m_axis_frame_tready) << cur_src) : '0;
            checkOutput("frame_tready_route", s_axis_frame_tready, exp_rdy);
            if (!in_frame) begin
               checkOutput("frame_tvalid_outside_record", m_axis_frame_tvalid, 0);
            end else if (m_axis_frame_tvalid) begin
               if (exp_frame.size() == 0) begin
                  checkOutput("frame_unexpected", 1, 0);
               end else if (m_axis_frame_tready) begin
                  checkOutput("frame_word", {m_axis_frame_tlast, m_axis_frame_tdata}, exp_frame[0]);
                  frames_seen++;
                  if (exp_frame[0][DW])
                     in_frame = 1'b0;
                  void'(exp_frame.pop_front());
               end else begin
                  checkOutput("frame_hold", {m_axis_frame_tlast, m_axis_frame_tdata}, exp_frame[0]);
               end
            end
            if (m_axis_ctl_tvalid) begin
               if (exp_ctl.size() == 0) begin
                  checkOutput("ctl_unexpected", 1, 0);
               end else if (m_axis_ctl_tready) begin
                  head = exp_ctl[0];
                  checkOutput("ctl_word", m_axis_ctl_tdata, head);
                  cur_src  = int'(head[OW-1 -: 4]);
                  in_frame = exp_words[0] > 0;
                  void'(exp_ctl.pop_front());
                  void'(exp_words.pop_front());
               end else begin
                  checkOutput("ctl_hold", m_axis_ctl_tdata, exp_ctl[0]);
               end
            end
         end
      end
   end

   initial begin
      int base;
      int n;
      rst      = 1'b0;
      enable   = 1'b0;
      rand_rdy = 1'b0;
      for (int i = 0; i < NS; i++) gap_at[i] = -1;
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
      srst = 1'b0;
`endif
      #1 rst = 1'b1;
      #2;
      checkOutput("rst_ctl_tvalid", m_axis_ctl_tvalid, 0);
      checkOutput("rst_ctl_tdata", m_axis_ctl_tdata, 0);
      checkOutput("rst_frame_tvalid", m_axis_frame_tvalid, 0);
      checkOutput("rst_frame_tdata", m_axis_frame_tdata, 0);
      checkOutput("rst_frame_tlast", m_axis_frame_tlast, 0);
      checkOutput("rst_s_ctl_tready", s_axis_ctl_tready, 0);
      checkOutput("rst_s_frame_tready", s_axis_frame_tready, 0);
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
      checkOutput("rst_record_count", record_count, 0);
      checkOutput("rst_stall_cycles", stall_cycles, 0);
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Both sources hold three records; strict alternation starting at source 0.
      for (int r = 0; r < 3; r++) begin
         applyStimulus(0, 16'd8, 8'(8'h10 + 2*r));
         applyStimulus(1, 16'd8, 8'(8'h11 + 2*r));
      end
      repeat (2) @(posedge clk);
      #1 enable = 1'b1;
      waitDone(200, "alternate_3x2");

      applyStimulus(0, 16'd13, 8'h20);
      waitDone(100, "single_size13");

      base = frames_seen;
      applyStimulus(1, 16'd0, 8'h30);
      waitDone(100, "size0_src1");
      checkOutput("size0_no_frames", frames_seen - base, 0);

      base = frames_seen;
      applyStimulus(0, 16'd16, 8'h40);
      applyStimulus(1, 16'd17, 8'h41);
      waitDone(100, "size16_size17");
      checkOutput("size16_17_word_total", frames_seen - base, 5);

      base = frames_seen;
      applyStimulus(1, 16'hFFFF, 8'h50);
      waitDone(10000, "size_ffff");
      checkOutput("size_ffff_words", frames_seen - base, 8192);

`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
      @(posedge clk);
      #1 srst = 1'b1;
      @(posedge clk);
      #1 srst = 1'b0;
`endif
      gap_at[0] = popped[0] + 2;
      rand_rdy  = 1'b1;
      applyStimulus(0, 16'd32, 8'h60);
      waitDone(2000, "random_ready_gap");
      rand_rdy = 1'b0;
`ifdef ETH_FRAME_LOG_ARBITER_STATS_EN
      checkOutput("stats_record_count", record_count, 1);
      checkOutput("stats_stall_cycles", stall_cycles, 5);
`endif

      // Source 1 wins first; enable drops mid-record and source 0 must wait.
      base = frames_seen;
      applyStimulus(1, 16'd32, 8'h70);
      applyStimulus(0, 16'd8, 8'h71);
      n = 0;
      while (frames_seen < base + 1 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      enable = 1'b0;
      n = 0;
      while (!(exp_ctl.size() == 1 && exp_frame.size() == 1) && n < 200) begin
         @(posedge clk);
         n++;
      end
      repeat (10) @(posedge clk);
      #2;
      checkOutput("disabled_record_finished", frames_seen - base, 4);
      checkOutput("disabled_no_grant", m_axis_ctl_tvalid, 0);
      checkOutput("disabled_pending", exp_ctl.size(), 1);
      enable = 1'b1;
      waitDone(100, "reenable");

      // Asynchronous reset in the middle of an 8-word record.
      base = frames_seen;
      applyStimulus(0, 16'd64, 8'h80);
      n = 0;
      while (frames_seen < base + 2 && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      #1 rst = 1'b1;
      for (int i = 0; i < NS; i++) begin
         src_ctl_q[i].delete();
         src_frame_q[i].delete();
      end
      exp_ctl.delete();
      exp_words.delete();
      exp_frame.delete();
      #1;
      checkOutput("midrst_ctl_tvalid", m_axis_ctl_tvalid, 0);
      checkOutput("midrst_frame_tvalid", m_axis_frame_tvalid, 0);
      checkOutput("midrst_frame_tready", s_axis_frame_tready, 0);
      checkOutput("midrst_frame_tlast", m_axis_frame_tlast, 0);
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
